// File: rtl/ex_alu_unit_pkg.sv
// Shared constants for the execute-stage ALU: control codes, ALUOp and funct3 encodings.
// The SLT/SLTU codes are only generated when ALU_SLT_EN is defined.
package ex_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // Compare codes live alongside the shifter in the datapath and need the macro.
  function automatic logic is_cmp_code(input logic [3:0] code);
    return (code == ALU_SLT) || (code == ALU_SLTU);
  endfunction

endpackage

// File: rtl/ex_alu_unit_if.sv
// Bundle of the execute-stage ALU signals; master drives operands/control, slave is the ALU.
interface ex_alu_unit_if #(
  parameter int N = 32
);

  logic         en;
  logic [1:0]   alu_op;
  logic [2:0]   funct3;
  logic         funct7_b5;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] rs1_data;
  logic [N-1:0] rs2_data;
  logic         branch;
  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         zero;
  logic [N-1:0] alu_result_q;
  logic         zero_q;
  logic         branch_taken;

  modport master (
    output en, alu_op, funct3, funct7_b5, op_a, op_b, rs1_data, rs2_data, branch,
    input  alu_ctrl, alu_result, zero, alu_result_q, zero_q, branch_taken
  );

  modport slave (
    input  en, alu_op, funct3, funct7_b5, op_a, op_b, rs1_data, rs2_data, branch,
    output alu_ctrl, alu_result, zero, alu_result_q, zero_q, branch_taken
  );

endinterface

// File: rtl/ex_alu_unit_ctrl_dec.sv
// Combinational ALU control decoder: ALUOp/funct3/funct7[5] -> 4-bit control code.
// With ALU_SLT_EN undefined, funct3 010/011 fall back to ADD.
import ex_alu_pkg::*;

module ex_alu_ctrl_dec (
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_b5_i,
  output logic [3:0] alu_ctrl_o
);

  logic is_r_type;

  assign is_r_type = (alu_op_i == ALUOP_R);

  // I-type arithmetic shares the R-type table except that funct7[5] never selects SUB.
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_MEM: alu_ctrl_o = ALU_ADD;
      ALUOP_BR:  alu_ctrl_o = ALU_SUB;
      default: begin
        case (funct3_i)
          F3_ADD:  alu_ctrl_o = (is_r_type && funct7_b5_i) ? ALU_SUB : ALU_ADD;
          F3_SLL:  alu_ctrl_o = ALU_SLL;
`ifdef ALU_SLT_EN
          F3_SLT:  alu_ctrl_o = ALU_SLT;
          F3_SLTU: alu_ctrl_o = ALU_SLTU;
`else
          F3_SLT:  alu_ctrl_o = ALU_ADD;
          F3_SLTU: alu_ctrl_o = ALU_ADD;
`endif
          F3_XOR:  alu_ctrl_o = ALU_XOR;
          F3_SR:   alu_ctrl_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
          F3_OR:   alu_ctrl_o = ALU_OR;
          F3_AND:  alu_ctrl_o = ALU_AND;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_alu_unit.sv
// Execute-stage ALU with registered result copy and ID-stage branch-equal resolution.
// Optional macro ALU_SLT_EN enables the SLT/SLTU compare operations.
import ex_alu_pkg::*;

module ex_alu_unit #(
  parameter int N = 32
) (
  input  logic          clk,
  input  logic          rst,
  ex_alu_unit_if.slave  bus_if
);

  logic [3:0]   alu_ctrl;
  logic [N-1:0] alu_result;
  logic         zero;
  logic [4:0]   shamt;
  logic [N-1:0] result_d;
  logic [N-1:0] result_q;
  logic         zero_d;
  logic         zero_q;

  ex_alu_ctrl_dec u_ctrl_dec (
    .alu_op_i    (bus_if.alu_op),
    .funct3_i    (bus_if.funct3),
    .funct7_b5_i (bus_if.funct7_b5),
    .alu_ctrl_o  (alu_ctrl)
  );

  assign shamt = bus_if.op_b[4:0];

  // Any code not listed (including compare codes when the macro is off) yields zero.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      ALU_AND:  alu_result = bus_if.op_a & bus_if.op_b;
      ALU_OR:   alu_result = bus_if.op_a | bus_if.op_b;
      ALU_XOR:  alu_result = bus_if.op_a ^ bus_if.op_b;
      ALU_ADD:  alu_result = bus_if.op_a + bus_if.op_b;
      ALU_SUB:  alu_result = bus_if.op_a - bus_if.op_b;
      ALU_SLL:  alu_result = bus_if.op_a << shamt;
      ALU_SRL:  alu_result = bus_if.op_a >> shamt;
      ALU_SRA:  alu_result = $signed(bus_if.op_a) >>> shamt;
`ifdef ALU_SLT_EN
      ALU_SLT:  alu_result = {{(N-1){1'b0}}, ($signed(bus_if.op_a) < $signed(bus_if.op_b))};
      ALU_SLTU: alu_result = {{(N-1){1'b0}}, (bus_if.op_a < bus_if.op_b)};
`endif
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  always_comb begin
    result_d = result_q;
    zero_d   = zero_q;
    if (bus_if.en) begin
      result_d = alu_result;
      zero_d   = zero;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus_if.alu_ctrl     = alu_ctrl;
  assign bus_if.alu_result   = alu_result;
  assign bus_if.zero         = zero;
  assign bus_if.alu_result_q = result_q;
  assign bus_if.zero_q       = zero_q;
  assign bus_if.branch_taken = bus_if.branch & (bus_if.rs1_data == bus_if.rs2_data);

endmodule

// File: tb/tb_ex_alu_unit.sv
// Self-checking bench for ex_alu_unit: directed vector table, reset/enable sequences, random vs model.
// Expectations follow ALU_SLT_EN the same way the design does.
module tb_ex_alu_unit;

  logic clk;
  logic rst;
  int   checks;
  int   fails;
  logic [31:0] expQ;
  logic        expZq;

  ex_alu_unit_if #(.N(32)) bus ();

  ex_alu_unit #(.N(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctrl;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[$];

  // Reference: which operation the spec selects, expressed as a control code.
  function automatic logic [3:0] refCtrl(input logic [1:0] op, input logic [2:0] f3, input logic f7);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    case (f3)
      3'b000: return (op == 2'b10 && f7) ? 4'b0110 : 4'b0010;
      3'b111: return 4'b0000;
      3'b110: return 4'b0001;
      3'b100: return 4'b0011;
      3'b001: return 4'b0100;
      3'b101: return f7 ? 4'b1101 : 4'b0101;
`ifdef ALU_SLT_EN
      3'b010: return 4'b0111;
      3'b011: return 4'b1000;
`endif
      default: return 4'b0010;
    endcase
  endfunction

  // Reference arithmetic using wide integer math rather than bit-level operators where possible.
  function automatic logic [31:0] refExec(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
    longint unsigned ua, ub, sum;
    int sh;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sh = int'(b[4:0]);
    case (code)
      4'b0010: begin sum = ua + ub; return sum[31:0]; end
      4'b0110: begin sum = ua + 64'h1_0000_0000 - ub; return sum[31:0]; end
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0100: begin sum = ua * (64'd1 << sh); return sum[31:0]; end
      4'b0101: begin sum = ua / (64'd1 << sh); return sum[31:0]; end
      4'b1101: begin
        if (a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
`ifdef ALU_SLT_EN
      4'b0111: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'b1000: return (ua < ub) ? 32'd1 : 32'd0;
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                               input logic [31:0] a, input logic [31:0] b);
    bus.alu_op    = op;
    bus.funct3    = f3;
    bus.funct7_b5 = f7;
    bus.op_a      = a;
    bus.op_b      = b;
  endtask

  // One clock edge; the model captures the current combinational expectation when en=1.
  task automatic stepClock(input logic en, input logic [31:0] curRes);
    bus.en = en;
    @(posedge clk);
    if (en && !rst) begin
      expQ  = curRes;
      expZq = (curRes == 32'd0);
    end
    #1;
    checkOutput("alu_result_q", bus.alu_result_q, expQ);
    checkOutput("zero_q", {31'd0, bus.zero_q}, {31'd0, expZq});
  endtask

  initial begin
    logic [1:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a, b, r;
    logic [3:0]  c;
    checks = 0;
    fails  = 0;
    expQ   = 32'd0;
    expZq  = 1'b0;

    vecs.push_back('{2'b00, 3'b000, 1'b0, 32'h100,      32'h4,      4'b0010, 32'h104});
    vecs.push_back('{2'b01, 3'b111, 1'b1, 32'h7,        32'h7,      4'b0110, 32'h0});
    vecs.push_back('{2'b10, 3'b000, 1'b0, 32'hFFFFFFFF, 32'h1,      4'b0010, 32'h0});
    vecs.push_back('{2'b10, 3'b000, 1'b1, 32'h5,        32'h7,      4'b0110, 32'hFFFFFFFE});
    vecs.push_back('{2'b10, 3'b111, 1'b0, 32'hF0F0,     32'h0FF0,   4'b0000, 32'h00F0});
    vecs.push_back('{2'b10, 3'b110, 1'b0, 32'hF0F0,     32'h0FF0,   4'b0001, 32'hFFF0});
    vecs.push_back('{2'b10, 3'b101, 1'b1, 32'h80000000, 32'h4,      4'b1101, 32'hF8000000});
    vecs.push_back('{2'b10, 3'b101, 1'b0, 32'h80000000, 32'h4,      4'b0101, 32'h08000000});
    vecs.push_back('{2'b11, 3'b000, 1'b1, 32'h5,        32'h7,      4'b0010, 32'hC});
    vecs.push_back('{2'b11, 3'b101, 1'b1, 32'h80000000, 32'h4,      4'b1101, 32'hF8000000});
    vecs.push_back('{2'b10, 3'b100, 1'b0, 32'hFF00,     32'h0F0F,   4'b0011, 32'hF00F});
    vecs.push_back('{2'b10, 3'b001, 1'b0, 32'h1,        32'h3F,     4'b0100, 32'h80000000});
`ifdef ALU_SLT_EN
    vecs.push_back('{2'b10, 3'b010, 1'b0, 32'hFFFFFFFF, 32'h1,      4'b0111, 32'h1});
    vecs.push_back('{2'b10, 3'b011, 1'b0, 32'hFFFFFFFF, 32'h1,      4'b1000, 32'h0});
`else
    vecs.push_back('{2'b10, 3'b010, 1'b0, 32'h3,        32'h4,      4'b0010, 32'h7});
    vecs.push_back('{2'b11, 3'b011, 1'b0, 32'h3,        32'h4,      4'b0010, 32'h7});
`endif

    rst = 1'b1;
    bus.en = 1'b0;
    bus.branch = 1'b0;
    bus.rs1_data = 32'd0;
    bus.rs2_data = 32'd0;
    applyStimulus(2'b00, 3'b000, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset alu_result_q", bus.alu_result_q, 32'd0);
    checkOutput("reset zero_q", {31'd0, bus.zero_q}, 32'd0);
    rst = 1'b0;

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
      #1;
      checkOutput($sformatf("vec%0d alu_ctrl", i), {28'd0, bus.alu_ctrl}, {28'd0, vecs[i].ctrl});
      checkOutput($sformatf("vec%0d alu_result", i), bus.alu_result, vecs[i].res);
      checkOutput($sformatf("vec%0d zero", i), {31'd0, bus.zero}, {31'd0, (vecs[i].res == 32'd0)});
      stepClock(1'b1, vecs[i].res);
    end

    $display("[TB] enable hold");
    applyStimulus(2'b00, 3'b000, 1'b0, 32'h100, 32'h4);
    #1;
    stepClock(1'b1, 32'h104);
    applyStimulus(2'b01, 3'b000, 1'b0, 32'h7, 32'h7);
    #1;
    stepClock(1'b0, 32'h0);
    checkOutput("hold alu_result_q", bus.alu_result_q, 32'h104);

    $display("[TB] async reset mid-cycle");
    applyStimulus(2'b00, 3'b000, 1'b0, 32'h12345678, 32'd0);
    #1;
    stepClock(1'b1, 32'h12345678);
    #2;
    rst = 1'b1;
    expQ = 32'd0;
    expZq = 1'b0;
    #1;
    checkOutput("async rst alu_result_q", bus.alu_result_q, 32'd0);
    checkOutput("async rst zero_q", {31'd0, bus.zero_q}, 32'd0);
    checkOutput("rst comb alu_result", bus.alu_result, 32'h12345678);
    stepClock(1'b1, 32'h12345678);
    #2;
    rst = 1'b0;

    $display("[TB] branch compare");
    bus.rs1_data = 32'hA5; bus.rs2_data = 32'hA5; bus.branch = 1'b1; #1;
    checkOutput("branch equal", {31'd0, bus.branch_taken}, 32'd1);
    bus.branch = 1'b0; #1;
    checkOutput("branch off", {31'd0, bus.branch_taken}, 32'd0);
    bus.rs2_data = 32'hA4; bus.branch = 1'b1; #1;
    checkOutput("branch unequal", {31'd0, bus.branch_taken}, 32'd0);

    $display("[TB] random vectors");
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = -a;
      applyStimulus(op, f3, f7, a, b);
      bus.rs1_data = $urandom;
      bus.rs2_data = ($urandom_range(0, 1) == 1) ? bus.rs1_data : 32'($urandom);
      bus.branch   = 1'($urandom_range(0, 1));
      c = refCtrl(op, f3, f7);
      r = refExec(c, a, b);
      #1;
      checkOutput("rand alu_ctrl", {28'd0, bus.alu_ctrl}, {28'd0, c});
      checkOutput("rand alu_result", bus.alu_result, r);
      checkOutput("rand zero", {31'd0, bus.zero}, {31'd0, (r == 32'd0)});
      checkOutput("rand branch_taken", {31'd0, bus.branch_taken},
                  {31'd0, (bus.branch == 1'b1) && (bus.rs1_data == bus.rs2_data)});
      stepClock(1'($urandom_range(0, 1)), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
